// File: rtl/uart_mem_responder.sv
// rtl/uart_mem_responder.sv - UART byte-protocol responder performing single-word memory reads/writes
module uart_mem_responder #(
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    input  logic        tx_full,
    output logic [7:0]  w_data,
    output logic        wr_uart,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_EXEC,
        S_REPLY
    } state_t;

    localparam logic [7:0]  CMD_WR   = 8'h57;
    localparam logic [7:0]  CMD_RD   = 8'h52;
    localparam logic [7:0]  BYTE_ACK = 8'h06;
    localparam logic [7:0]  BYTE_NAK = 8'h15;
    // When TIMEOUT is 0 this wraps to all-ones, but the compare is disabled then.
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [1:0]  rlast_q, rlast_d;
    logic [1:0]  ridx_q, ridx_d;
    logic [7:0]  err_q, err_d;
    logic        err_inc;
    logic        tmo_hit;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            rbuf_q  <= '0;
            rlast_q <= '0;
            ridx_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            rbuf_q  <= rbuf_d;
            rlast_q <= rlast_d;
            ridx_q  <= ridx_d;
            err_q   <= err_d;
        end
    end

    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

    // Next-state and field assembly; a pop always wins over an expiring timeout
    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        rbuf_d  = rbuf_q;
        rlast_d = rlast_q;
        ridx_d  = ridx_q;
        err_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_uart) begin
                    is_wr_d = (r_data == CMD_WR);
                    if (r_data == CMD_WR || r_data == CMD_RD) begin
                        state_d = S_ADDR;
                        cnt_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        state_d = S_REPLY;
                        rbuf_d  = {24'h0, BYTE_NAK};
                        rlast_d = 2'd0;
                        ridx_d  = 2'd0;
                        err_inc = 1'b1;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (rd_uart) begin
                    tmo_d = '0;
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == S_ADDR) begin
                        addr_d[{cnt_q, 3'b000} +: 8] = r_data;
                    end else begin
                        data_d[{cnt_q, 3'b000} +: 8] = r_data;
                    end
                    if (cnt_q == 2'd3) begin
                        cnt_d = '0;
                        if (state_q == S_ADDR && is_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    err_inc = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_EXEC: begin
                state_d = S_REPLY;
                ridx_d  = 2'd0;
                rlast_d = 2'd0;
                if (addr_q[1:0] != 2'b00) begin
                    rbuf_d  = {24'h0, BYTE_NAK};
                    err_inc = 1'b1;
                end else if (is_wr_q) begin
                    rbuf_d = {24'h0, BYTE_ACK};
                end else begin
                    rbuf_d  = mem_rdata;
                    rlast_d = 2'd3;
                end
            end
            S_REPLY: begin
                if (wr_uart) begin
                    if (ridx_q == rlast_q) begin
                        ridx_d  = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        ridx_d = ridx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    // Handshakes and memory strobe; reset suppresses them in the cycle it is applied
    always_comb begin
        rd_uart = !reset && !rx_empty &&
                  (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
        wr_uart = !reset && !tx_full && (state_q == S_REPLY);
        mem_we  = !reset && (state_q == S_EXEC) && is_wr_q && (addr_q[1:0] == 2'b00);
        busy    = (state_q != S_IDLE);
    end

    assign w_data    = rbuf_q[{ridx_q, 3'b000} +: 8];
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_uart_mem_responder.sv
// tb/tb_uart_mem_responder.sv - directed self-checking bench for uart_mem_responder
module tb_uart_mem_responder;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        tx_full = 1'b0;
    logic        rd_uart, wr_uart, mem_we, busy;
    logic [7:0]  w_data, err_cnt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    uart_mem_responder #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    bit          mem_ready = 1'b0;
    assign mem_rdata = mem[mem_addr[7:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    int          txc[$];
    int          popc[$];
    int          we_cnt = 0, we_cyc = 0, viol = 0;
    logic [31:0] we_addr = '0, we_data = '0;
    bit          pend_pop = 1'b0, pend_we = 1'b0;
    logic [31:0] pend_a = '0, pend_d = '0;

    // FIFO and RAM models: apply last edge's handshakes, present new head, then sample handshakes
    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'h0;
            mem[0] = 32'h04030201;
            mem_ready = 1'b1;
        end
        if (pend_pop && rxq.size() != 0) void'(rxq.pop_front());
        pend_pop = 1'b0;
        if (pend_we) mem[pend_a[7:2]] = pend_d;
        pend_we = 1'b0;
        rx_empty = (rxq.size() == 0);
        r_data = rx_empty ? 8'h00 : rxq[0];
        #1;
        if ((rd_uart && (rx_empty || reset)) || (wr_uart && tx_full)) viol++;
        if (rd_uart) begin
            pend_pop = 1'b1;
            popc.push_back(cyc);
        end
        if (wr_uart) begin
            txq.push_back(w_data);
            txc.push_back(cyc);
        end
        if (mem_we) begin
            pend_we = 1'b1;
            pend_a = mem_addr;
            pend_d = mem_wdata;
            we_cnt++;
            we_cyc = cyc;
            we_addr = mem_addr;
            we_data = mem_wdata;
        end
    end

    int tests_run = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear();
        txq.delete();
        txc.delete();
        popc.delete();
    endtask

    task automatic wait_rx_drained();
        int n = 0;
        while (rxq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("rx_drain_bound", n < 100, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((rxq.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("idle_bound", n < budget, 1);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                              input logic [31:0] d, input int nb, input bit gaps);
        logic [7:0] f[9];
        f[0] = cmd;
        for (int i = 0; i < 4; i++) begin
            f[1+i] = a[8*i +: 8];
            f[5+i] = d[8*i +: 8];
        end
        for (int i = 0; i < nb; i++) begin
            rxq.push_back(f[i]);
            if (gaps) begin
                wait_rx_drained();
                repeat ($urandom_range(0, 8)) tick();
            end
        end
    endtask

    task automatic expect_reply(input string tag, input int n, input logic [31:0] exp);
        check({tag, "_len"}, txq.size(), n);
        for (int i = 0; i < n && i < txq.size(); i++) begin
            check({tag, "_byte"}, txq[i], exp[8*i +: 8]);
            if (i > 0) check({tag, "_gap"}, txc[i] - txc[i-1], 1);
        end
    endtask

    initial begin
        int p;
        // Reset: outputs at reset values, no pop while reset is high
        repeat (3) tick();
        rxq.push_back(8'h33);
        tick();
        check("rst_rd_uart", rd_uart, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_w_data", w_data, 8'h00);
        check("rst_err", err_cnt, 8'h00);
        rxq.delete();
        tick();
        reset = 1'b0;
        tick();

        // Back-to-back write frame
        clear();
        send_frame(8'h57, 32'h10, 32'hDEADBEEF, 9, 1'b0);
        wait_idle(200);
        check("wr_we_cnt", we_cnt, 1);
        check("wr_addr", we_addr, 32'h10);
        check("wr_data", we_data, 32'hDEADBEEF);
        check("wr_pops", popc.size(), 9);
        expect_reply("wr_ack", 1, 32'h06);
        if (popc.size() == 9 && txc.size() == 1) begin
            check("wr_span", popc[8] - popc[0], 8);
            check("wr_we_lat", we_cyc - popc[8], 1);
            check("wr_ack_lat", txc[0] - popc[8], 2);
        end
        check("wr_busy", busy, 0);
        check("wr_hold_addr", mem_addr, 32'h10);
        check("wr_hold_data", mem_wdata, 32'hDEADBEEF);

        // Read back
        clear();
        send_frame(8'h52, 32'h10, 32'h0, 5, 1'b0);
        wait_idle(200);
        check("rd_no_we", we_cnt, 1);
        expect_reply("rd", 4, 32'hDEADBEEF);
        if (popc.size() == 5 && txc.size() != 0) check("rd_lat", txc[0] - popc[4], 2);

        // Unknown command and misaligned write
        clear();
        rxq.push_back(8'h33);
        wait_idle(50);
        expect_reply("nak_cmd", 1, 32'h15);
        check("nak_cmd_err", err_cnt, 1);
        clear();
        send_frame(8'h57, 32'h12, 32'h55, 9, 1'b0);
        wait_idle(200);
        check("nak_mis_we", we_cnt, 1);
        expect_reply("nak_mis", 1, 32'h15);
        check("nak_mis_err", err_cnt, 2);

        // Transmit back-pressure during a read reply
        clear();
        tx_full = 1'b1;
        send_frame(8'h52, 32'h10, 32'h0, 5, 1'b0);
        repeat (55) tick();
        check("flow_none_sent", txq.size(), 0);
        check("flow_q0_held", w_data, 8'hEF);
        check("flow_busy", busy, 1);
        tx_full = 1'b0;
        wait_idle(50);
        expect_reply("flow", 4, 32'hDEADBEEF);

        // Random gaps between received bytes
        clear();
        send_frame(8'h57, 32'h20, 32'hCAFEF00D, 9, 1'b1);
        wait_idle(200);
        check("gap_we_cnt", we_cnt, 2);
        check("gap_addr", we_addr, 32'h20);
        check("gap_data", we_data, 32'hCAFEF00D);
        expect_reply("gap_ack", 1, 32'h06);
        clear();
        send_frame(8'h52, 32'h20, 32'h0, 5, 1'b1);
        wait_idle(200);
        expect_reply("gap_rd", 4, 32'hCAFEF00D);
        check("gap_err", err_cnt, 2);

        // Timeout after a partial frame
        clear();
        send_frame(8'h57, 32'h10, 32'h0, 3, 1'b0);
        wait_rx_drained();
        check("tmo_pops", popc.size(), 3);
        p = (popc.size() != 0) ? popc[popc.size()-1] : cyc;
        while (cyc < p + 16) tick();
        check("tmo_busy_last", busy, 1);
        tick();
        check("tmo_busy_after", busy, 0);
        check("tmo_err", err_cnt, 3);
        check("tmo_no_reply", txq.size(), 0);
        check("tmo_no_we", we_cnt, 2);
        clear();
        send_frame(8'h52, 32'h0, 32'h0, 5, 1'b0);
        wait_idle(200);
        expect_reply("tmo_next_rd", 4, 32'h04030201);

        // Error counter saturation
        clear();
        repeat (300) rxq.push_back(8'h33);
        wait_idle(3000);
        check("sat_err", err_cnt, 8'hFF);
        check("sat_naks", txq.size(), 300);

        // Reset mid-frame after the 6th byte
        clear();
        send_frame(8'h57, 32'h30, 32'h11223344, 6, 1'b0);
        wait_rx_drained();
        reset = 1'b1;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_wdata", mem_wdata, 32'h0);
        check("mid_rst_w_data", w_data, 8'h00);
        check("mid_rst_err", err_cnt, 8'h00);
        check("mid_rst_rd_uart", rd_uart, 0);
        reset = 1'b0;
        tick();
        check("mid_rst_no_we", we_cnt, 2);
        clear();
        send_frame(8'h57, 32'h30, 32'h11223344, 9, 1'b0);
        wait_idle(200);
        check("post_rst_we_cnt", we_cnt, 3);
        check("post_rst_addr", we_addr, 32'h30);
        check("post_rst_data", we_data, 32'h11223344);
        expect_reply("post_rst_ack", 1, 32'h06);
        tick();
        check("post_rst_mem", mem[12], 32'h11223344);

        check("handshake_blocked", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/uart_mem_responder.md
# uart_mem_responder

Far-end responder for the byte-oriented UART memory-access protocol that CPU software drives over its UART link. It sits behind a `uart` instance on the companion side. It pops command bytes from the receive FIFO, assembles 32-bit addresses and data, and performs single-word reads and writes on a `ram`-style memory port. It pushes ACK, NAK or read-data bytes back through the transmit FIFO.

## Interface
Parameters:
- TIMEOUT, 100000: maximum idle cycles allowed between bytes inside a frame. 0 disables the timeout.

Ports:
- clk  in  1  system clock. One clock domain only.
- reset  in  1  synchronous, active-high reset.
- rx_empty  in  1  receive FIFO empty flag.
- r_data  in  8  receive FIFO head byte. First-word-fall-through: valid whenever rx_empty=0.
- rd_uart  out  1  pops the receive FIFO head at the clock edge.
- tx_full  in  1  transmit FIFO full flag.
- w_data  out  8  byte to transmit.
- wr_uart  out  1  pushes w_data into the transmit FIFO at the clock edge.
- mem_addr  out  32  memory address, driven from the address register.
- mem_wdata  out  32  memory write data, driven from the data register.
- mem_we  out  1  memory write enable, one cycle wide.
- mem_rdata  in  32  memory read data. Combinational with respect to mem_addr.
- busy  out  1  high whenever state ≠ IDLE.
- err_cnt  out  8  saturating protocol error count.

## Operation
- Protocol bytes, all multi-byte fields little-endian:
  - Write: 0x57, A0..A3, D0..D3. Reply: 0x06 (ACK).
  - Read: 0x52, A0..A3. Reply: Q0..Q3 = mem_rdata, LSB first.
  - Unknown command byte, or misaligned address (A[1:0] ≠ 0): reply 0x15 (NAK), and err_cnt increments.
- Receive handshake: rd_uart = (state in IDLE/ADDR/DATA) && !rx_empty, combinational. A byte counts as consumed only in a cycle where rd_uart=1.
- Transmit handshake: wr_uart = (state == REPLY) && !tx_full, combinational. w_data = reply byte selected by the reply index.
- Neither handshake output is ever asserted while its FIFO flag blocks it.
- States:
  - IDLE: on pop, latch the command. 0x57 or 0x52 → ADDR with cnt=0. Any other value → REPLY (NAK, length 1), err_cnt++.
  - ADDR: on each pop, addr[8*cnt +: 8] ← r_data and cnt++. On the 4th byte, cnt clears; write → DATA, read → EXEC.
  - DATA: same as ADDR, filling data. On the 4th byte → EXEC.
  - EXEC: lasts exactly one cycle.
    - Misaligned address: NAK reply (length 1), err_cnt++, mem_we stays 0.
    - Write: mem_we=1, reply ACK (length 1).
    - Read: reply buffer ← mem_rdata, reply length 4.
    - All cases → REPLY.
  - REPLY: on each wr_uart, the reply index increments. After the last byte → IDLE.
- Timeout:
  - The counter clears on every pop and on entry to ADDR.
  - It increments in ADDR/DATA on cycles with no pop.
  - When it reaches TIMEOUT−1 with TIMEOUT ≠ 0: → IDLE with no reply, err_cnt++, partial fields discarded.
- err_cnt saturates at 255.
- mem_addr and mem_wdata hold their values after an operation until overwritten.

## Timing
- Reset (synchronous): state=IDLE, addr=0, data=0, cnt=0, timeout counter=0, reply buffer=0, err_cnt=0.
  - Outputs during and after reset: busy=0, mem_we=0, mem_addr=0, mem_wdata=0, w_data=0x00.
  - rd_uart is 0 while reset is high.
- A reset mid-frame or mid-reply aborts immediately. Unsent reply bytes are dropped and nothing is written to memory.
- Throughput: at most one byte popped per cycle with no bubble. A back-to-back 9-byte write frame occupies cycles 0–8.
- Write latency: last data byte popped at cycle N → mem_we=1 at N+1 → ACK pushed at N+2 if tx_full=0.
- Read latency: A3 popped at cycle N → mem_rdata sampled at N+1 → Q0..Q3 pushed at N+2..N+5 if tx_full stays 0.
- tx_full=1 stalls REPLY indefinitely with no timeout. Receive bytes remain in the FIFO (rd_uart=0 outside IDLE/ADDR/DATA).
- rx_empty=1 mid-frame stalls. Stalls are bounded only by TIMEOUT.
- A new command is accepted in the cycle after the last reply byte is pushed.

## Test plan
- Write: push 57 10 00 00 00 EF BE AD DE with no gaps → single mem_we pulse with addr=0x10, wdata=0xDEADBEEF; tx byte 0x06 at N+2; busy returns to 0.
- Read back: memory model holds 0xDEADBEEF at 0x10; push 52 10 00 00 00 → tx EF BE AD DE in consecutive cycles; mem_we never asserted.
- Errors: push 0x33 → NAK 0x15, err_cnt=1. Push write to 0x12 → NAK, no mem_we, err_cnt=2. Force 300 errors → err_cnt=255.
- Flow control: hold tx_full=1 for 50 cycles during a read reply → wr_uart stays 0 and Q0 is held; release → all 4 bytes in order. Gaps of random length (< TIMEOUT) between received bytes → identical results.
- Timeout: TIMEOUT=16; push 57 10 00, then stall 16 cycles → IDLE, err_cnt++, no reply. A following 52 00 00 00 00 is served correctly.
- Reset: assert reset for 1 cycle after the 6th byte of a write frame → no mem_we, all registers and outputs at reset values; the next full frame completes normally.
